// File: rtl/otter_ctrl_pkg.sv
// otter_ctrl_pkg: control types and constants shared by the OTTER
// sequencer and hazard unit.
package otter_ctrl_pkg;
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;
  typedef enum logic [1:0] {RUN, DRAIN, TRAP} seq_state_t;
  localparam logic [31:0] NOP_IR = 32'h00000013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; a clear beats an increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = CLR ? '0 : (INC && q_q != {W{1'b1}}) ? q_q + {{(W-1){1'b0}}, 1'b1} : q_q;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) q_q <= '0;
    else q_q <= q_d;
  assign Q = q_q;
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: stall/flush/interrupt sequencer for the 5-stage OTTER
// pipeline, with stage valid tracking and saturating perf counters.
module pipeline_sequencer
  import otter_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HAZ_STALL,
  input  logic             BR_TAKEN,
  input  logic             IMEM_READY,
  input  logic             DMEM_REQ,
  input  logic             DMEM_READY,
  input  logic             INTR,
  input  logic             INTR_EN,
  input  logic             CNT_CLR,
  output logic             PC_EN,
  output logic             IF_DE_EN,
  output logic             DE_EX_EN,
  output logic             EX_ME_EN,
  output logic             ME_WB_EN,
  output logic             IF_DE_FLUSH,
  output logic             DE_EX_FLUSH,
  output logic             PC_SEL_TRAP,
  output logic             CAPTURE_EPC,
  output logic             INTR_TAKEN,
  output logic             VALID_DE,
  output logic             VALID_EX,
  output logic             VALID_ME,
  output logic             VALID_WB,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);
  seq_state_t state_q, state_d;
  logic valid_de_q, valid_ex_q, valid_me_q, valid_wb_q;
  logic valid_de_d, valid_ex_d, valid_me_d, valid_wb_d;
  logic freeze, pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en;
  logic if_de_flush, de_ex_flush, pc_sel_trap, capture_epc, intr_taken;
  logic stall_inc, flush_inc;
  // A flushed register still loads (a bubble), so its enable is set alongside the flush.
  always_comb begin
    freeze = valid_me_q & DMEM_REQ & ~DMEM_READY;
    state_d = state_q;
    {pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en} = '0;
    {if_de_flush, de_ex_flush, pc_sel_trap, capture_epc, intr_taken} = '0;
    {stall_inc, flush_inc} = '0;
    case (state_q)
      RUN: begin
        if (freeze) begin
          stall_inc = 1'b1;
        end else if (HAZ_STALL && valid_de_q) begin
          {de_ex_en, ex_me_en, me_wb_en, de_ex_flush, stall_inc} = '1;
        end else if (BR_TAKEN && valid_de_q) begin
          {pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en, if_de_flush, flush_inc} = '1;
        end else if (INTR && INTR_EN && valid_de_q) begin
          {if_de_en, de_ex_en, ex_me_en, me_wb_en, if_de_flush, de_ex_flush, capture_epc} = '1;
          state_d = DRAIN;
        end else if (!IMEM_READY) begin
          {if_de_en, de_ex_en, ex_me_en, me_wb_en, if_de_flush} = '1;
        end else begin
          {pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en} = '1;
        end
      end
      DRAIN: begin
        {if_de_en, de_ex_en, if_de_flush, de_ex_flush} = '1;
        ex_me_en = ~freeze;
        me_wb_en = ~freeze;
        state_d = (valid_ex_q | valid_me_q | valid_wb_q) ? DRAIN : TRAP;
      end
      TRAP: begin
        {pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en, if_de_flush} = '1;
        {pc_sel_trap, intr_taken} = '1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    valid_de_d = if_de_flush ? 1'b0 : if_de_en ? 1'b1 : valid_de_q;
    valid_ex_d = de_ex_flush ? 1'b0 : de_ex_en ? valid_de_q : valid_ex_q;
    valid_me_d = ex_me_en ? valid_ex_q : valid_me_q;
    valid_wb_d = me_wb_en ? valid_me_q : valid_wb_q;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= RUN;
      {valid_de_q, valid_ex_q, valid_me_q, valid_wb_q} <= '0;
    end else begin
      state_q <= state_d;
      {valid_de_q, valid_ex_q, valid_me_q, valid_wb_q} <= {valid_de_d, valid_ex_d, valid_me_d, valid_wb_d};
    end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK(CLK), .RST_N(RST_N), .CLR(CNT_CLR), .INC(stall_inc), .Q(STALL_CNT)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK(CLK), .RST_N(RST_N), .CLR(CNT_CLR), .INC(flush_inc), .Q(FLUSH_CNT)
  );
  assign {PC_EN, IF_DE_EN, DE_EX_EN, EX_ME_EN, ME_WB_EN} =
    {pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en} & {5{RST_N}};
  assign {IF_DE_FLUSH, DE_EX_FLUSH, PC_SEL_TRAP, CAPTURE_EPC, INTR_TAKEN} =
    {if_de_flush, de_ex_flush, pc_sel_trap, capture_epc, intr_taken} & {5{RST_N}};
  assign {VALID_DE, VALID_EX, VALID_ME, VALID_WB} = {valid_de_q, valid_ex_q, valid_me_q, valid_wb_q};
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed and randomized checks of pipeline_sequencer
// against a stage-list reference model.
module tb_pipeline_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic haz_stall, br_taken, imem_ready, dmem_req, dmem_ready, intr, intr_en, cnt_clr;
  logic pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en, if_de_flush, de_ex_flush;
  logic pc_sel_trap, capture_epc, intr_taken, valid_de, valid_ex, valid_me, valid_wb;
  logic [31:0] stall_cnt, flush_cnt;
  logic pc_en4, if_de_en4, de_ex_en4, ex_me_en4, me_wb_en4, if_de_flush4, de_ex_flush4;
  logic pc_sel_trap4, capture_epc4, intr_taken4, valid_de4, valid_ex4, valid_me4, valid_wb4;
  logic [3:0] stall_cnt4, flush_cnt4;
  logic [9:0] vec;
  logic [3:0] vld;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .CLK(clk), .RST_N(rst_n), .HAZ_STALL(haz_stall), .BR_TAKEN(br_taken),
    .IMEM_READY(imem_ready), .DMEM_REQ(dmem_req), .DMEM_READY(dmem_ready),
    .INTR(intr), .INTR_EN(intr_en), .CNT_CLR(cnt_clr),
    .PC_EN(pc_en), .IF_DE_EN(if_de_en), .DE_EX_EN(de_ex_en), .EX_ME_EN(ex_me_en),
    .ME_WB_EN(me_wb_en), .IF_DE_FLUSH(if_de_flush), .DE_EX_FLUSH(de_ex_flush),
    .PC_SEL_TRAP(pc_sel_trap), .CAPTURE_EPC(capture_epc), .INTR_TAKEN(intr_taken),
    .VALID_DE(valid_de), .VALID_EX(valid_ex), .VALID_ME(valid_me), .VALID_WB(valid_wb),
    .STALL_CNT(stall_cnt), .FLUSH_CNT(flush_cnt)
  );

  pipeline_sequencer #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .HAZ_STALL(haz_stall), .BR_TAKEN(br_taken),
    .IMEM_READY(imem_ready), .DMEM_REQ(dmem_req), .DMEM_READY(dmem_ready),
    .INTR(intr), .INTR_EN(intr_en), .CNT_CLR(cnt_clr),
    .PC_EN(pc_en4), .IF_DE_EN(if_de_en4), .DE_EX_EN(de_ex_en4), .EX_ME_EN(ex_me_en4),
    .ME_WB_EN(me_wb_en4), .IF_DE_FLUSH(if_de_flush4), .DE_EX_FLUSH(de_ex_flush4),
    .PC_SEL_TRAP(pc_sel_trap4), .CAPTURE_EPC(capture_epc4), .INTR_TAKEN(intr_taken4),
    .VALID_DE(valid_de4), .VALID_EX(valid_ex4), .VALID_ME(valid_me4), .VALID_WB(valid_wb4),
    .STALL_CNT(stall_cnt4), .FLUSH_CNT(flush_cnt4)
  );

  assign vec = {pc_en, if_de_en, de_ex_en, ex_me_en, me_wb_en,
                if_de_flush, de_ex_flush, pc_sel_trap, capture_epc, intr_taken};
  assign vld = {valid_wb, valid_me, valid_ex, valid_de};

  // Reference model: the pipeline is a list of occupied stages (bit0=DE .. bit3=WB);
  // each cycle is classified as one action that moves the list.
  localparam int A_FREEZE = 0, A_STALL = 1, A_BRANCH = 2, A_INTR = 3, A_NOFETCH = 4;
  localparam int A_ADV = 5, A_DRAIN = 6, A_DRAINFZ = 7, A_TRAP = 8;
  localparam int P_RUN = 0, P_DRAIN = 1, P_TRAP = 2;
  int m_phase;
  logic [3:0] m_v;
  logic [31:0] m_sc, m_fc;
  logic [3:0] m_sc4, m_fc4;

  function automatic int act();
    bit fz = m_v[2] && dmem_req && !dmem_ready;
    if (m_phase == P_DRAIN) return fz ? A_DRAINFZ : A_DRAIN;
    if (m_phase == P_TRAP) return A_TRAP;
    if (fz) return A_FREEZE;
    if (haz_stall && m_v[0]) return A_STALL;
    if (br_taken && m_v[0]) return A_BRANCH;
    if (intr && intr_en && m_v[0]) return A_INTR;
    if (!imem_ready) return A_NOFETCH;
    return A_ADV;
  endfunction

  // {PC,IF_DE,DE_EX,EX_ME,ME_WB enables, IF_DE/DE_EX flush, trap sel, epc, taken}
  function automatic logic [9:0] exp_vec(input int a);
    case (a)
      A_FREEZE:  return 10'b00000_00000;
      A_STALL:   return 10'b00111_01000;
      A_BRANCH:  return 10'b11111_10000;
      A_INTR:    return 10'b01111_11010;
      A_NOFETCH: return 10'b01111_10000;
      A_ADV:     return 10'b11111_00000;
      A_DRAIN:   return 10'b01111_11000;
      A_DRAINFZ: return 10'b01100_11000;
      default:   return 10'b11111_10101;
    endcase
  endfunction

  function automatic logic [3:0] next_v(input int a);
    case (a)
      A_FREEZE:                    return m_v;
      A_STALL:                     return {m_v[2], m_v[1], 1'b0, m_v[0]};
      A_INTR, A_DRAIN:             return {m_v[2], m_v[1], 2'b00};
      A_DRAINFZ:                   return {m_v[3], m_v[2], 2'b00};
      A_ADV:                       return {m_v[2], m_v[1], m_v[0], 1'b1};
      default:                     return {m_v[2], m_v[1], m_v[0], 1'b0};
    endcase
  endfunction

  function automatic int next_phase(input int a);
    if (a == A_INTR) return P_DRAIN;
    if (a == A_DRAIN || a == A_DRAINFZ) return (m_v[3:1] == 3'b000) ? P_TRAP : P_DRAIN;
    return P_RUN;
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_phase <= P_RUN; m_v <= '0; m_sc <= '0; m_fc <= '0; m_sc4 <= '0; m_fc4 <= '0;
    end else begin
      m_phase <= next_phase(act());
      m_v <= next_v(act());
      m_sc <= cnt_clr ? 32'd0 : ((act() == A_FREEZE || act() == A_STALL) && m_sc != 32'hFFFF_FFFF) ? m_sc + 32'd1 : m_sc;
      m_fc <= cnt_clr ? 32'd0 : (act() == A_BRANCH && m_fc != 32'hFFFF_FFFF) ? m_fc + 32'd1 : m_fc;
      m_sc4 <= cnt_clr ? 4'd0 : ((act() == A_FREEZE || act() == A_STALL) && m_sc4 != 4'hF) ? m_sc4 + 4'd1 : m_sc4;
      m_fc4 <= cnt_clr ? 4'd0 : (act() == A_BRANCH && m_fc4 != 4'hF) ? m_fc4 + 4'd1 : m_fc4;
    end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    {haz_stall, br_taken, dmem_req, intr, intr_en, cnt_clr} = '0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
  endtask

  // Four advancing cycles with a counter clear: pipeline full, counters zero.
  task automatic fill();
    nxt(); idle(); cnt_clr = 1'b1;
    nxt(); cnt_clr = 1'b0;
    repeat (2) nxt();
  endtask

  task automatic test_reset();
    fill();
    nxt(); haz_stall = 1'b1; #1;
    nxt(); haz_stall = 1'b0; #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL pre_reset_stall_cnt: got %0d expected 1", stall_cnt); end
    rst_n = 1'b0; #1;
    n_checks++;
    if (vec !== 10'd0) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", vec, 10'd0); end
    n_checks++;
    if (vld !== 4'd0) begin n_fail++; $display("FAIL reset_valids: got %b expected 0000", vld); end
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    nxt(); rst_n = 1'b1; #1;
    nxt(); #1;
    n_checks++;
    if (valid_de !== 1'b1) begin n_fail++; $display("FAIL reset_release_valid_de: got %b expected 1", valid_de); end
  endtask

  task automatic test_load_use();
    fill();
    nxt(); haz_stall = 1'b1; #1;
    n_checks++;
    if (vec !== 10'b00111_01000) begin n_fail++; $display("FAIL load_use_ctrl: got %b expected %b", vec, 10'b00111_01000); end
    nxt(); haz_stall = 1'b0; #1;
    n_checks++;
    if (valid_ex !== 1'b0 || stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_use_after: got valid_ex=%b stall=%0d expected 0/1", valid_ex, stall_cnt);
    end
    n_checks++;
    if (vec !== 10'b11111_00000) begin n_fail++; $display("FAIL load_use_resume: got %b expected %b", vec, 10'b11111_00000); end
  endtask

  task automatic test_branch();
    fill();
    nxt(); br_taken = 1'b1; #1;
    n_checks++;
    if (vec !== 10'b11111_10000) begin n_fail++; $display("FAIL branch_ctrl: got %b expected %b", vec, 10'b11111_10000); end
    nxt(); br_taken = 1'b0; intr = 1'b1; intr_en = 1'b1; #1;
    n_checks++;
    if (valid_de !== 1'b0 || flush_cnt !== 32'd1) begin
      n_fail++; $display("FAIL branch_after: got valid_de=%b flush=%0d expected 0/1", valid_de, flush_cnt);
    end
    n_checks++;
    if (capture_epc !== 1'b0) begin n_fail++; $display("FAIL intr_deferred: got %b expected 0", capture_epc); end
    nxt(); intr = 1'b0; intr_en = 1'b0; br_taken = 1'b1; haz_stall = 1'b1; #1;
    n_checks++;
    if (vec !== 10'b00111_01000) begin n_fail++; $display("FAIL branch_vs_stall: got %b expected %b", vec, 10'b00111_01000); end
    nxt(); br_taken = 1'b0; haz_stall = 1'b0; #1;
    n_checks++;
    if (flush_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL branch_vs_stall_cnt: got flush=%0d stall=%0d expected 1/1", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_dmem_wait();
    fill();
    for (int k = 0; k < 3; k++) begin
      nxt(); dmem_req = 1'b1; dmem_ready = 1'b0; #1;
      n_checks++;
      if (vec !== 10'd0 || vld !== 4'hF) begin
        n_fail++; $display("FAIL dmem_freeze_%0d: got ctrl=%b valids=%b expected 0/1111", k, vec, vld);
      end
    end
    nxt(); dmem_ready = 1'b1; #1;
    n_checks++;
    if (vec !== 10'b11111_00000 || vld !== 4'hF || stall_cnt !== 32'd3) begin
      n_fail++; $display("FAIL dmem_release: got ctrl=%b valids=%b stall=%0d expected %b/1111/3", vec, vld, stall_cnt, 10'b11111_00000);
    end
    dmem_req = 1'b0;
  endtask

  task automatic test_interrupt(input bit with_wait, input int exp_n);
    int n = -1;
    fill();
    nxt(); intr = 1'b1; intr_en = 1'b1; #1;
    n_checks++;
    if (capture_epc !== 1'b1 || vec !== 10'b01111_11010) begin
      n_fail++; $display("FAIL intr_entry: got %b expected %b", vec, 10'b01111_11010);
    end
    for (int k = 1; k <= 20 && n < 0; k++) begin
      nxt(); intr = 1'b0; dmem_req = with_wait && k <= 2; dmem_ready = !(with_wait && k <= 2); #1;
      if (intr_taken === 1'b1) begin
        n = k;
        n_checks++;
        if (pc_sel_trap !== 1'b1 || pc_en !== 1'b1) begin
          n_fail++; $display("FAIL trap_ctrl: got pc_sel_trap=%b pc_en=%b expected 1/1", pc_sel_trap, pc_en);
        end
      end
    end
    n_checks++;
    if (n != exp_n) begin n_fail++; $display("FAIL intr_taken_cycle: got %0d expected %0d", n, exp_n); end
    nxt(); #1;
    n_checks++;
    if (vec !== 10'b11111_00000) begin n_fail++; $display("FAIL intr_back_to_run: got %b expected %b", vec, 10'b11111_00000); end
  endtask

  task automatic test_saturation();
    fill();
    repeat (20) begin nxt(); haz_stall = 1'b1; end
    nxt(); cnt_clr = 1'b1; #1;
    n_checks++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 32'd20) begin
      n_fail++; $display("FAIL stall_saturation: got %0d/%0d expected 15/20", stall_cnt4, stall_cnt);
    end
    nxt(); haz_stall = 1'b0; cnt_clr = 1'b0; #1;
    n_checks++;
    if (stall_cnt4 !== 4'd0 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL clear_beats_inc: got %0d/%0d expected 0/0", stall_cnt4, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      nxt();
      haz_stall  = $urandom_range(0, 3) == 0;
      br_taken   = $urandom_range(0, 3) == 0;
      imem_ready = $urandom_range(0, 4) != 0;
      dmem_req   = $urandom_range(0, 1) == 1;
      dmem_ready = $urandom_range(0, 2) != 0;
      intr       = $urandom_range(0, 9) == 0;
      intr_en    = $urandom_range(0, 1) == 1;
      cnt_clr    = $urandom_range(0, 60) == 0;
      #1;
      n_checks++;
      if (vec !== exp_vec(act())) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", i, vec, exp_vec(act())); end
      n_checks++;
      if (vld !== m_v) begin n_fail++; $display("FAIL rand_valids[%0d]: got %b expected %b", i, vld, m_v); end
      n_checks++;
      if (stall_cnt !== m_sc || flush_cnt !== m_fc) begin
        n_fail++; $display("FAIL rand_cnt32[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cnt, flush_cnt, m_sc, m_fc);
      end
      n_checks++;
      if (stall_cnt4 !== m_sc4 || flush_cnt4 !== m_fc4) begin
        n_fail++; $display("FAIL rand_cnt4[%0d]: got %0d/%0d expected %0d/%0d", i, stall_cnt4, flush_cnt4, m_sc4, m_fc4);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    nxt(); #1;
    n_checks++;
    if (vec !== 10'd0 || vld !== 4'd0) begin n_fail++; $display("FAIL power_on_reset: got ctrl=%b valids=%b expected 0", vec, vld); end
    rst_n = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_dmem_wait();
    test_interrupt(1'b0, 4);
    test_interrupt(1'b1, 6);
    test_saturation();
    repeat (10) nxt();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central stall/flush sequencer for the 5-stage OTTER pipeline (IF, DE, EX, ME, WB).
- Combines four inputs into per-register enable and flush controls:
  - the hazard unit's STALL,
  - branch resolution in DE,
  - instruction/data memory wait states,
  - interrupt requests.
- Tracks per-stage valid bits.
- Runs the interrupt-entry sequence: drain, then trap redirect.
- Keeps saturating stall and flush performance counters.

Parameters:
- CNT_W, 32, width of STALL_CNT and FLUSH_CNT.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- HAZ_STALL  in  1  hazard unit stall request for the instruction in DE.
- BR_TAKEN  in  1  branch/jump in DE redirects PC this cycle.
- IMEM_READY  in  1  instruction fetch data valid this cycle.
- DMEM_REQ  in  1  ME-stage instruction is a load/store.
- DMEM_READY  in  1  data memory completes this cycle.
- INTR  in  1  interrupt pending (level).
- INTR_EN  in  1  CSR interrupt enable.
- CNT_CLR  in  1  synchronous clear of both counters.
- PC_EN, IF_DE_EN, DE_EX_EN, EX_ME_EN, ME_WB_EN  out  1 each  pipeline register load enables.
- IF_DE_FLUSH, DE_EX_FLUSH  out  1 each  load a bubble (NOP, valid=0) instead of the upstream value.
- PC_SEL_TRAP  out  1  PC mux selects trap vector.
- CAPTURE_EPC  out  1  latch DE-stage PC into mepc.
- INTR_TAKEN  out  1  one-cycle interrupt-entry pulse.
- VALID_DE, VALID_EX, VALID_ME, VALID_WB  out  1 each  stage valid bits.
- STALL_CNT, FLUSH_CNT  out  CNT_W each  saturating performance counters.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - state=RUN; all VALID_*=0; counters=0.
  - All enables, flushes, PC_SEL_TRAP, CAPTURE_EPC and INTR_TAKEN are forced 0 while RST_N=0.
- States: RUN, DRAIN, TRAP.
- freeze = VALID_ME & DMEM_REQ & !DMEM_READY.
- RUN, first matching rule wins:
  1. freeze: all *_EN=0, no flush, valids hold; STALL_CNT+1.
  2. HAZ_STALL & VALID_DE:
     - PC_EN=0, IF_DE_EN=0, DE_EX_FLUSH=1, EX_ME_EN=ME_WB_EN=1.
     - STALL_CNT+1. BR_TAKEN is ignored (operands not ready).
  3. BR_TAKEN & VALID_DE:
     - all EN=1, IF_DE_FLUSH=1 (kill wrong-path fetch).
     - FLUSH_CNT+1.
  4. INTR & INTR_EN & VALID_DE:
     - CAPTURE_EPC=1, PC_EN=0, IF_DE_FLUSH=1, DE_EX_FLUSH=1, EX_ME_EN=ME_WB_EN=1.
     - Go to DRAIN. The DE instruction is discarded and is the restart point.
  5. !IMEM_READY: PC_EN=0, IF_DE_FLUSH=1, downstream EN=1.
  6. Otherwise: all EN=1, VALID_DE next=1.
- Interrupts are deferred while VALID_DE=0 (e.g. the cycle after a branch flush).
- DRAIN:
  - PC_EN=0, IF_DE_FLUSH=1, DE_EX_FLUSH=1.
  - EX_ME_EN=ME_WB_EN=!freeze.
  - When VALID_EX=VALID_ME=VALID_WB=0 at the clock edge, go to TRAP.
  - INTR deassertion during DRAIN does not abort entry.
- TRAP (exactly 1 cycle):
  - INTR_TAKEN=1, PC_SEL_TRAP=1, PC_EN=1, IF_DE_FLUSH=1, other EN=1.
  - Next state RUN.
- Valid update:
  - A stage's valid takes 0 when its input register is flushed.
  - Otherwise it takes the upstream valid when enabled; otherwise it holds.
  - VALID_WB clears when ME_WB_EN=1 and VALID_ME=0.
- Counters:
  - +1 per qualifying cycle; saturate at 2^CNT_W-1.
  - CNT_CLR wins over increment.
- Outputs other than counters/valids/state are combinational from state and inputs; no added latency.

Decomposition:
- Package otter_ctrl_pkg holds:
  - opcode_t, shared with the hazard unit;
  - seq_state_t {RUN, DRAIN, TRAP};
  - constant NOP_IR = 32'h00000013.
- One sub-module: sat_counter (parameter W; inputs CLK, RST_N, CLR, INC; output Q), instantiated twice.

Test Plan:
- Reset: assert RST_N=0 mid-stream with a full pipeline → all EN/flush=0 immediately, valids=0, STALL_CNT=FLUSH_CNT=0; after release, VALID_DE=1 one cycle later.
- Load-use: full pipeline, HAZ_STALL=1 for 1 cycle → PC_EN=0, IF_DE_EN=0, DE_EX_FLUSH=1, VALID_EX=0 next cycle, STALL_CNT=1; following cycle all EN=1.
- Branch: BR_TAKEN=1 → IF_DE_FLUSH=1, PC_EN=1, VALID_DE=0 next, FLUSH_CNT=1; BR_TAKEN=1 with HAZ_STALL=1 → stall behaviour, FLUSH_CNT unchanged.
- DMEM wait: DMEM_REQ=1, VALID_ME=1, DMEM_READY=0 for 3 cycles → all EN=0 for exactly 3 cycles, valids unchanged, STALL_CNT=3.
- Interrupt: full pipeline, INTR=INTR_EN=1 at cycle N:
  - CAPTURE_EPC at N;
  - DRAIN for N+1..N+3;
  - INTR_TAKEN=PC_SEL_TRAP=1 at N+4 only;
  - RUN at N+5.
  - Repeat with DMEM_READY low 2 cycles during DRAIN → INTR_TAKEN at N+6.
- Saturation with CNT_W=4: 20 consecutive stall cycles → STALL_CNT=15; CNT_CLR=1 coincident with a stall → 0 next cycle.
